// File: rtl/package_settings.sv
// package_settings
// Shared data-path sizing for the v19 acquisition chain.
//   SIZE_FILTER_DATA : width of the signed filter samples and trigger levels.
package package_settings;

  localparam int SIZE_FILTER_DATA = 16;

endpackage : package_settings

// File: rtl/v19_filter_parameters.sv
// v19_filter_parameters
// Sequencer-side constants for the v19 trapezoidal shaping filter.
//   k_19 / l_19      : filter rise and flat-top lengths in cycles.
//   *_DEF constants  : defaults for the sequencer timing parameters.
//   CNT_W            : width of the sequencer's phase counter.
//   v19_seq_state_e  : sequencer FSM states.
package v19_filter_parameters;

  localparam int k_19 = 16;
  localparam int l_19 = 8;

  localparam int SETTLE_CYC_DEF = k_19 + l_19 + 8;
  localparam int MAX_TRACK_DEF  = k_19 + l_19 + 4;
  localparam int DEAD_CYC_DEF   = k_19 + l_19;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ARMED  = 3'd2,
    TRACK  = 3'd3,
    DEAD   = 3'd4
  } v19_seq_state_e;

endpackage : v19_filter_parameters

// File: rtl/v19_event_slot.sv
// v19_event_slot
// One-deep registered event buffer with valid/ready output and a saturating
// lost-event counter.
// Ports:
//   clk, reset        : clock, synchronous active-low reset.
//   load              : an event is offered this cycle (amp_in/time_in).
//   drop              : an event was rejected upstream; count it as lost.
//   ev_valid/ev_ready : downstream handshake; ev_amp/ev_time held while stalled.
//   drop_cnt          : lost events, saturating at 255.
module v19_event_slot
  import package_settings::*;
#(
  parameter int TS_W = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic                               drop,
  input  logic signed [SIZE_FILTER_DATA-1:0] amp_in,
  input  logic        [TS_W-1:0]             time_in,
  input  logic                               ev_ready,
  output logic                               ev_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] ev_amp,
  output logic        [TS_W-1:0]             ev_time,
  output logic        [7:0]                  drop_cnt
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic                               valid_q, valid_d;
  logic signed [SIZE_FILTER_DATA-1:0] amp_q, amp_d;
  logic        [TS_W-1:0]             time_q, time_d;
  logic        [7:0]                  drop_q, drop_d;
  logic                               accept_s;
  logic                               slot_free_s;

  // A slot being drained this cycle can take the new event in the same cycle.
  assign accept_s    = valid_q && ev_ready;
  assign slot_free_s = !valid_q || accept_s;

  // Slot next-state: load, drain, or count a lost event.
  always_comb begin
    valid_d = valid_q;
    amp_d   = amp_q;
    time_d  = time_q;
    drop_d  = drop_q;
    if (load && slot_free_s) begin
      valid_d = 1'b1;
      amp_d   = amp_in;
      time_d  = time_in;
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if ((load && !slot_free_s) || drop) begin
      drop_d = sat_inc8(drop_q);
    end else begin
      drop_d = drop_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      amp_q   <= '0;
      time_q  <= '0;
      drop_q  <= 8'd0;
    end else begin
      valid_q <= valid_d;
      amp_q   <= amp_d;
      time_q  <= time_d;
      drop_q  <= drop_d;
    end
  end

  assign ev_valid = valid_q;
  assign ev_amp   = amp_q;
  assign ev_time  = time_q;
  assign drop_cnt = drop_q;

endmodule : v19_event_slot

// File: rtl/v19_filter_sequencer.sv
// v19_filter_sequencer
// Acquisition sequencer for the v19 shaping filter: drives the filter reset,
// waits out settling, detects pulses, captures peak and crossing timestamp,
// and hands events to the readout through v19_event_slot.
// Ports:
//   clk, reset            : clock, synchronous active-low reset.
//   enable                : acquisition run level.
//   threshold, filt_data  : signed trigger level and filter sample.
//   filt_rst_n            : active-low reset to the filter.
//   ev_valid/ev_ready     : event handshake; ev_amp = peak, ev_time = crossing ts.
//   busy                  : sequencer not idle.   drop_cnt : lost events (sat 255).
// Build option: define V19_SEQ_PILEUP_REJECT_EN to defer commit to the end of
// dead time and reject events that see another crossing during dead time.
module v19_filter_sequencer
  import package_settings::*;
  import v19_filter_parameters::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int MAX_TRACK  = MAX_TRACK_DEF,
  parameter int DEAD_CYC   = DEAD_CYC_DEF,
  parameter int TS_W       = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  input  logic signed [SIZE_FILTER_DATA-1:0] filt_data,
  output logic                               filt_rst_n,
  output logic                               ev_valid,
  input  logic                               ev_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] ev_amp,
  output logic        [TS_W-1:0]             ev_time,
  output logic                               busy,
  output logic        [7:0]                  drop_cnt
);

  v19_seq_state_e                     state_q, state_d;
  logic        [CNT_W-1:0]            cnt_q, cnt_d;
  logic        [TS_W-1:0]             ts_q, ts_d;
  logic signed [SIZE_FILTER_DATA-1:0] amp_q, amp_d;
  logic        [TS_W-1:0]             time_q, time_d;
  logic                               filt_rst_n_q, filt_rst_n_d;
  logic                               busy_q, busy_d;
  logic                               above_s;
  logic signed [SIZE_FILTER_DATA-1:0] amp_max_s;
  logic signed [SIZE_FILTER_DATA-1:0] commit_amp_s;
  logic                               commit_s;
  logic                               drop_s;
`ifdef V19_SEQ_PILEUP_REJECT_EN
  logic                               pileup_q, pileup_d;
`endif

  assign above_s   = filt_data > threshold;
  assign amp_max_s = (filt_data > amp_q) ? filt_data : amp_q;

`ifdef V19_SEQ_PILEUP_REJECT_EN
  // Peak is final once TRACK has ended.
  assign commit_amp_s = amp_q;
`else
  // Committing in the last TRACK cycle, so fold in the current sample.
  assign commit_amp_s = amp_max_s;
`endif

  // FSM next state, phase counter, timestamp and staged event.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    amp_d    = amp_q;
    time_d   = time_q;
    commit_s = 1'b0;
    drop_s   = 1'b0;
`ifdef V19_SEQ_PILEUP_REJECT_EN
    pileup_d = pileup_q;
`endif
    ts_d = ((state_q == IDLE) || (state_q == SETTLE)) ? '0 : ts_q + TS_W'(1);

    if (!enable) begin
      // Staged event is discarded silently; the output slot keeps its event.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            state_d = SETTLE;
          end
        end
        ARMED: begin
          cnt_d = '0;
          if (above_s) begin
            state_d = TRACK;
            amp_d   = filt_data;
            time_d  = ts_q;
          end else begin
            state_d = ARMED;
          end
        end
        TRACK: begin
          amp_d = amp_max_s;
          if (!above_s || (cnt_q == CNT_W'(MAX_TRACK - 1))) begin
            state_d = DEAD;
            cnt_d   = '0;
`ifdef V19_SEQ_PILEUP_REJECT_EN
            pileup_d = 1'b0;
`else
            commit_s = 1'b1;
`endif
          end else begin
            state_d = TRACK;
          end
        end
        DEAD: begin
`ifdef V19_SEQ_PILEUP_REJECT_EN
          pileup_d = pileup_q || above_s;
`endif
          if (cnt_q == CNT_W'(DEAD_CYC - 1)) begin
            state_d = ARMED;
            cnt_d   = '0;
`ifdef V19_SEQ_PILEUP_REJECT_EN
            if (pileup_q || above_s) begin
              drop_s = 1'b1;
            end else begin
              commit_s = 1'b1;
            end
`endif
          end else begin
            state_d = DEAD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Registered status follows the next state so it tracks state_q exactly.
    filt_rst_n_d = (state_d != IDLE);
    busy_d       = (state_d != IDLE);
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ts_q         <= '0;
      amp_q        <= '0;
      time_q       <= '0;
      filt_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef V19_SEQ_PILEUP_REJECT_EN
      pileup_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ts_q         <= ts_d;
      amp_q        <= amp_d;
      time_q       <= time_d;
      filt_rst_n_q <= filt_rst_n_d;
      busy_q       <= busy_d;
`ifdef V19_SEQ_PILEUP_REJECT_EN
      pileup_q     <= pileup_d;
`endif
    end
  end

  assign filt_rst_n = filt_rst_n_q;
  assign busy       = busy_q;

  v19_event_slot #(
    .TS_W (TS_W)
  ) u_slot (
    .clk      (clk),
    .reset    (reset),
    .load     (commit_s),
    .drop     (drop_s),
    .amp_in   (commit_amp_s),
    .time_in  (time_q),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_amp   (ev_amp),
    .ev_time  (ev_time),
    .drop_cnt (drop_cnt)
  );

endmodule : v19_filter_sequencer

// File: tb/tb_v19_filter_sequencer.sv
// Directed bench for v19_filter_sequencer with SETTLE_CYC=4, MAX_TRACK=8,
// DEAD_CYC=3, threshold=100. Inputs change 1 time unit after the rising edge
// and outputs are checked at that same point.
module tb_v19_filter_sequencer;
  import package_settings::*;

  logic                               clk;
  logic                               reset;
  logic                               enable;
  logic signed [SIZE_FILTER_DATA-1:0] threshold;
  logic signed [SIZE_FILTER_DATA-1:0] filt_data;
  logic                               filt_rst_n;
  logic                               ev_valid;
  logic                               ev_ready;
  logic signed [SIZE_FILTER_DATA-1:0] ev_amp;
  logic        [31:0]                 ev_time;
  logic                               busy;
  logic        [7:0]                  drop_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  v19_filter_sequencer #(
    .SETTLE_CYC (4),
    .MAX_TRACK  (8),
    .DEAD_CYC   (3),
    .TS_W       (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .threshold  (threshold),
    .filt_data  (filt_data),
    .filt_rst_n (filt_rst_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_amp     (ev_amp),
    .ev_time    (ev_time),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_frst"}, 64'(filt_rst_n), 64'd0);
    check_val({tag, "_valid"}, 64'(ev_valid), 64'd0);
    check_val({tag, "_amp"}, 64'(ev_amp), 64'd0);
    check_val({tag, "_time"}, 64'(ev_time), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  // One-sample pulse from ARMED; returns right after the TRACK-exit edge.
  task automatic pulse(input logic signed [SIZE_FILTER_DATA-1:0] pk);
    filt_data = pk;
    tick(1);
    filt_data = 16'sd0;
    tick(1);
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    ev_ready  = 1'b0;
    threshold = 16'sd100;
    filt_data = 16'sd0;

    // Start-up
    tick(3);
    check_reset_vals("rst");
    reset = 1'b1;
    tick(1);
    check_val("idle_frst", 64'(filt_rst_n), 64'd0);
    enable = 1'b1;
    tick(1);                            // E: enable sampled, SETTLE
    check_val("settle_frst", 64'(filt_rst_n), 64'd1);
    check_val("settle_busy", 64'(busy), 64'd1);
    tick(1);
    filt_data = 16'sd300;               // crossing during SETTLE is ignored
    tick(2);
    filt_data = 16'sd0;
    tick(1);                            // E+4: ARMED, ts=0
    ev_ready = 1'b1;
    tick(1);                            // ts=1

    // Single pulse 120,300,250,90
    filt_data = 16'sd120; tick(1);
    filt_data = 16'sd300; tick(1);
    filt_data = 16'sd250; tick(1);
    check_val("sp_pre_valid", 64'(ev_valid), 64'd0);
    filt_data = 16'sd90;  tick(1);      // last TRACK cycle sampled
    check_val("sp_valid", 64'(ev_valid), 64'd1);
    check_val("sp_amp", 64'(ev_amp), 64'd300);
    check_val("sp_time", 64'(ev_time), 64'd1);
    filt_data = 16'sd0;
    tick(1);
    check_val("sp_valid_fall", 64'(ev_valid), 64'd0);

    // Long pulse held at 500
    tick(2);                            // E+12: ARMED, ts=8
    filt_data = 16'sd500;
    tick(8);                            // E+20: 8th TRACK cycle
    check_val("lp_pre_valid", 64'(ev_valid), 64'd0);
    tick(1);
    check_val("lp_valid", 64'(ev_valid), 64'd1);
    check_val("lp_amp", 64'(ev_amp), 64'd500);
    check_val("lp_time", 64'(ev_time), 64'd8);
    tick(11);
    check_val("rearm_pre_valid", 64'(ev_valid), 64'd0);
    tick(1);                            // re-armed at ts=20 after 3 DEAD cycles
    check_val("rearm_valid", 64'(ev_valid), 64'd1);
    check_val("rearm_time", 64'(ev_time), 64'd20);
    filt_data = 16'sd0;
    tick(1);
    check_val("rearm_valid_fall", 64'(ev_valid), 64'd0);
    ev_ready = 1'b0;
    tick(2);                            // ARMED, ts=32

    // Back-pressure
    pulse(16'sd150);
    check_val("bp1_valid", 64'(ev_valid), 64'd1);
    check_val("bp1_amp", 64'(ev_amp), 64'd150);
    check_val("bp1_time", 64'(ev_time), 64'd32);
    tick(3);
    pulse(16'sd180);
    check_val("bp2_valid", 64'(ev_valid), 64'd1);
    check_val("bp2_amp_held", 64'(ev_amp), 64'd150);
    check_val("bp2_time_held", 64'(ev_time), 64'd32);
    check_val("bp2_drop", 64'(drop_cnt), 64'd1);
    tick(3);
    for (int i = 0; i < 300; i++) begin
      pulse(16'sd200);
      tick(3);
    end
    check_val("sat_drop", 64'(drop_cnt), 64'd255);
    check_val("sat_amp_held", 64'(ev_amp), 64'd150);
    ev_ready = 1'b1;
    tick(1);
    check_val("bp_drain", 64'(ev_valid), 64'd0);

    // Load in the same cycle as a handshake keeps ev_valid high
    ev_ready = 1'b0;
    pulse(16'sd130);
    check_val("hs_first_amp", 64'(ev_amp), 64'd130);
    tick(3);
    filt_data = 16'sd140;
    tick(1);
    filt_data = 16'sd0;
    ev_ready  = 1'b1;
    tick(1);
    check_val("hs_valid_kept", 64'(ev_valid), 64'd1);
    check_val("hs_new_amp", 64'(ev_amp), 64'd140);
    tick(1);
    check_val("hs_valid_fall", 64'(ev_valid), 64'd0);
    tick(2);                            // ARMED

    // Abort by enable=0 on what would be the TRACK exit cycle
    filt_data = 16'sd400;
    tick(1);
    filt_data = 16'sd50;
    enable    = 1'b0;
    tick(1);
    check_val("ab_frst", 64'(filt_rst_n), 64'd0);
    check_val("ab_busy", 64'(busy), 64'd0);
    check_val("ab_valid", 64'(ev_valid), 64'd0);
    check_val("ab_drop", 64'(drop_cnt), 64'd255);
    tick(2);
    check_val("ab_no_event", 64'(ev_valid), 64'd0);

    // Reset low mid-pulse
    enable = 1'b1;
    tick(5);                            // SETTLE x4, now ARMED
    ev_ready  = 1'b0;
    filt_data = 16'sd400;
    tick(2);
    reset     = 1'b0;
    filt_data = 16'sd50;
    tick(1);
    check_reset_vals("midrst");

    // Second crossing during DEAD
    reset     = 1'b1;
    filt_data = 16'sd0;
    tick(5);                            // SETTLE x4, now ARMED
    ev_ready = 1'b1;
    pulse(16'sd150);
`ifdef V19_SEQ_PILEUP_REJECT_EN
    check_val("pu_commit_valid", 64'(ev_valid), 64'd0);
`else
    check_val("pu_commit_valid", 64'(ev_valid), 64'd1);
    check_val("pu_commit_amp", 64'(ev_amp), 64'd150);
`endif
    filt_data = 16'sd200;
    tick(1);
    filt_data = 16'sd0;
    tick(2);                            // end of DEAD, ARMED again
    check_val("pu_valid", 64'(ev_valid), 64'd0);
`ifdef V19_SEQ_PILEUP_REJECT_EN
    check_val("pu_drop", 64'(drop_cnt), 64'd1);
`else
    check_val("pu_drop", 64'(drop_cnt), 64'd0);
    check_val("pu_amp_first_peak", 64'(ev_amp), 64'd150);
`endif
    tick(2);
    check_val("pu_no_extra_event", 64'(ev_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_v19_filter_sequencer
